mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch requester and its data (load/store) requester. Each requester keeps its own address, data and active-low acknowledge handshake. The arbiter serialises requests onto the single memory port, gives data priority with a starvation guard for fetch, and bounds every access with a timeout. It sits between the core and the external memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, max consecutive data grants while a fetch is pending
TIMEOUT, 255, max BUSY cycles waiting for m_ack_n before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request, level
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data, valid while i_ack_n=0
i_ack_n  out  1  fetch acknowledge, active-low one-cycle pulse
d_req  in  1  data request, level
d_write  in  1  1=store, 0=load
d_size  in  2  00 word, 01 half, 10 byte
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data, right-aligned
d_rdata  out  DATA_W  load data, valid while d_ack_n=0
d_ack_n  out  1  data acknowledge, active-low one-cycle pulse
m_req  out  1  memory request
m_write  out  1  memory write
m_size  out  2  memory access size
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, sampled when m_ack_n=0
m_ack_n  in  1  memory acknowledge, active-low
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE.
  - m_req=0, m_write=0, m_size=00, m_addr=0, m_wdata=0.
  - i_ack_n=1, d_ack_n=1, i_rdata=0, d_rdata=0, err=0.
  - starve_cnt=0, timeout counter=0.
- All outputs are registered.
- FSM states:
  - IDLE:
    - If d_req and (starve_cnt<STARVE_MAX or !i_req): grant data. Latch d_addr, d_size, d_write, and d_wdata (stored as 0 when d_write=0). Go to BUSY.
    - Else if i_req: grant fetch. Latch i_addr, force size=00 and write=0. Go to BUSY.
    - Else stay in IDLE.
  - BUSY:
    - m_req=1 and the latched fields drive m_*. m_req first asserts the cycle after the grant decision.
    - Requester inputs are ignored; a withdrawn request still completes.
    - On m_ack_n=0: capture m_rdata, go to RESP.
    - Else increment the timeout counter. When it reaches TIMEOUT, go to RESP with captured data=0 and set the abort flag.
  - RESP:
    - m_req=0.
    - Pulse the granted requester's ack_n=0 for exactly one cycle, with its rdata equal to the captured value (0 on abort; stores also return the captured value).
    - err=1 this cycle on abort.
    - Go to IDLE.
    - The non-granted requester's ack_n stays 1 and its rdata holds its previous value.
- Latency: request seen in IDLE at cycle N, m_req high from N+1. m_ack_n low at cycle M gives requester ack_n low at M+1, then IDLE at M+2. Minimum 3 cycles per access.
- Requesters must deassert req in the cycle ack_n is low. A req still high in IDLE is treated as a new request.
- Starvation counter:
  - Increments on each data grant made while i_req=1.
  - Clears on any fetch grant, or on a data grant made while i_req=0.
  - Saturates at STARVE_MAX.
- Simultaneous i_req and d_req: data wins unless starve_cnt==STARVE_MAX.
- m_ack_n=0 arriving while in IDLE or RESP is ignored.
- Timeout and ack in the same cycle: the ack wins and there is no err.
- Size encoding and address are passed through unchanged; byte-lane placement is the memory's job.

Test Plan:
1. Fetch only: i_req=1, i_addr=0x0000_0010; memory acks the first BUSY cycle with 0x0000_0013 -> m_req=1, m_addr=0x10, m_size=00, m_write=0 one cycle after the request; i_ack_n=0 for one cycle with i_rdata=0x0000_0013; d_ack_n stays 1.
2. Same-cycle i_req (0x0000_0020) and load d_req (0x8000_0004, size 00, mem data 0xDEAD_BEEF) -> data served first with d_rdata=0xDEAD_BEEF; fetch follows immediately after return to IDLE.
3. Starvation: d_req and i_req held continuously, memory acks instantly -> grant order D,D,D,D,I,D,D,D,D,I...
4. Store byte: d_write=1, d_size=10, d_addr=0xF000_0000, d_wdata=0x0000_0041 -> m_write=1, m_size=10, m_wdata=0x41, m_addr=0xF000_0000; single d_ack_n pulse.
5. Timeout: load with m_ack_n held 1 -> after TIMEOUT=255 BUSY cycles, err=1 and d_ack_n=0 in the same cycle, d_rdata=0, then IDLE. Same setup with ack in cycle 255 -> no err.
6. Reset asserted mid-BUSY (async, between edges) -> m_req=0, all ack_n=1, err=0 immediately; after release, a new fetch is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port with data priority,
// a fetch starvation guard and a per-access timeout. All outputs are registered.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack_n,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack_n,
    output logic              m_req,
    output logic              m_write,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack_n,
    output logic              err
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] SMAX_C = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
    localparam logic [TO_W-1:0] TMO_C  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              gnt_data_q;
    logic              grant_data;
    logic              m_req_q, m_write_q;
    logic [1:0]        m_size_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              i_ack_n_q, d_ack_n_q, err_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    // Data wins unless fetch has been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_data = d_req && ((starve_q < SMAX_C) || !i_req);
        tmo_d      = tmo_q + TO_ONE;
        starve_d   = '0;
        if (i_req)
            starve_d = (starve_q == SMAX_C) ? starve_q : starve_q + SC_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            tmo_q      <= '0;
            gnt_data_q <= 1'b0;
            m_req_q    <= 1'b0;
            m_write_q  <= 1'b0;
            m_size_q   <= 2'b00;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_ack_n_q  <= 1'b1;
            d_ack_n_q  <= 1'b1;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        gnt_data_q <= 1'b1;
                        m_req_q    <= 1'b1;
                        m_write_q  <= d_write;
                        m_size_q   <= d_size;
                        m_addr_q   <= d_addr;
                        m_wdata_q  <= d_write ? d_wdata : '0;
                        starve_q   <= starve_d;
                        tmo_q      <= '0;
                        state_q    <= BUSY;
                    end else if (i_req) begin
                        gnt_data_q <= 1'b0;
                        m_req_q    <= 1'b1;
                        m_write_q  <= 1'b0;
                        m_size_q   <= 2'b00;
                        m_addr_q   <= i_addr;
                        m_wdata_q  <= '0;
                        starve_q   <= '0;
                        tmo_q      <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final timeout cycle still counts as success.
                    if (!m_ack_n || tmo_d == TMO_C) begin
                        m_req_q <= 1'b0;
                        err_q   <= m_ack_n;
                        state_q <= RESP;
                        if (gnt_data_q) begin
                            d_ack_n_q <= 1'b0;
                            d_rdata_q <= m_ack_n ? '0 : m_rdata;
                        end else begin
                            i_ack_n_q <= 1'b0;
                            i_rdata_q <= m_ack_n ? '0 : m_rdata;
                        end
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                RESP: begin
                    i_ack_n_q <= 1'b1;
                    d_ack_n_q <= 1'b1;
                    err_q     <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_req   = m_req_q;
    assign m_write = m_write_q;
    assign m_size  = m_size_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack_n = i_ack_n_q;
    assign d_ack_n = d_ack_n_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_bus_arbiter;
    localparam int AW = 32, DW = 32, SMAX = 4, TMO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_write = 1'b0;
    logic [1:0] d_size = 2'b00;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, m_rdata = '0;
    logic m_ack_n = 1'b1;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic i_ack_n, d_ack_n, m_req, m_write, err;
    logic [1:0] m_size;
    logic [AW-1:0] m_addr;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
        .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: one access in flight; it ends on ack or after TMO unanswered
    // cycles, and the requester is answered in the following cycle.
    bit m_act, m_pulse, e_gd;
    int m_wcnt, m_starve;
    logic e_mreq, e_mwrite, e_iack, e_dack, e_err;
    logic [1:0] e_msize;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwdata, e_irdata, e_drdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 0; m_pulse <= 0; m_wcnt <= 0; m_starve <= 0; e_gd <= 0;
            e_mreq <= 0; e_mwrite <= 0; e_msize <= 0; e_maddr <= '0; e_mwdata <= '0;
            e_iack <= 1; e_dack <= 1; e_irdata <= '0; e_drdata <= '0; e_err <= 0;
        end else begin
            e_iack <= 1; e_dack <= 1; e_err <= 0;
            if (m_pulse) begin
                m_pulse <= 0;
            end else if (m_act) begin
                if (!m_ack_n || m_wcnt + 1 >= TMO) begin
                    m_act <= 0; m_pulse <= 1; e_mreq <= 0; e_err <= m_ack_n;
                    if (e_gd) begin e_dack <= 0; e_drdata <= m_ack_n ? '0 : m_rdata; end
                    else begin e_iack <= 0; e_irdata <= m_ack_n ? '0 : m_rdata; end
                end else begin
                    m_wcnt <= m_wcnt + 1;
                end
            end else if (d_req && (m_starve < SMAX || !i_req)) begin
                m_act <= 1; m_wcnt <= 0; e_gd <= 1; e_mreq <= 1;
                e_mwrite <= d_write; e_msize <= d_size; e_maddr <= d_addr;
                e_mwdata <= d_write ? d_wdata : '0;
                m_starve <= i_req ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
            end else if (i_req) begin
                m_act <= 1; m_wcnt <= 0; e_gd <= 0; e_mreq <= 1;
                e_mwrite <= 0; e_msize <= 2'b00; e_maddr <= i_addr; m_starve <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_req", m_req, e_mreq);
            chk("i_ack_n", i_ack_n, e_iack);
            chk("d_ack_n", d_ack_n, e_dack);
            chk("err", err, e_err);
            chk("i_rdata", i_rdata, e_irdata);
            chk("d_rdata", d_rdata, e_drdata);
            if (e_mreq) begin
                chk("m_write", m_write, e_mwrite);
                chk("m_size", m_size, e_msize);
                chk("m_addr", m_addr, e_maddr);
                if (e_gd) chk("m_wdata", m_wdata, e_mwdata);
            end
        end
    end

    // Memory responder: 0 random (incl. stray acks), 1 ack first BUSY cycle,
    // 2 never ack, 3 ack on BUSY cycle ack_at.
    int mode = 2, ack_at = 0, mbusy = 0, nb;
    bit seen;
    logic [DW-1:0] mdata = '0;
    byte glog[$];
    string exp_order;

    task automatic cyc();
        @(negedge clk);
        mbusy = m_req ? mbusy + 1 : 0;
        case (mode)
            0: m_ack_n = m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) != 0);
            1: m_ack_n = !(mbusy >= 1);
            3: m_ack_n = !(mbusy == ack_at);
            default: m_ack_n = 1'b1;
        endcase
        m_rdata = (mode == 0) ? DW'($urandom) : mdata;
    endtask

    initial begin
        cyc(); cyc();
        chk("rst m_req", m_req, 0); chk("rst m_addr", m_addr, 0);
        chk("rst m_size", m_size, 0); chk("rst m_write", m_write, 0);
        chk("rst m_wdata", m_wdata, 0); chk("rst i_ack_n", i_ack_n, 1);
        chk("rst d_ack_n", d_ack_n, 1); chk("rst err", err, 0);
        chk("rst i_rdata", i_rdata, 0); chk("rst d_rdata", d_rdata, 0);
        rst = 1'b0;

        // Fetch only
        mode = 1; mdata = 32'h0000_0013; i_req = 1; i_addr = 32'h10;
        cyc();
        chk("t1 m_req", m_req, 1); chk("t1 m_addr", m_addr, 32'h10);
        chk("t1 m_size", m_size, 0); chk("t1 m_write", m_write, 0);
        cyc();
        chk("t1 i_ack_n", i_ack_n, 0); chk("t1 i_rdata", i_rdata, 32'h13);
        chk("t1 d_ack_n", d_ack_n, 1);
        i_req = 0;
        cyc();
        chk("t1 ack once", i_ack_n, 1); chk("t1 idle", m_req, 0);

        // Simultaneous: data first, fetch right after
        mdata = 32'hDEAD_BEEF; i_req = 1; i_addr = 32'h20;
        d_req = 1; d_write = 0; d_size = 2'b00; d_addr = 32'h8000_0004; d_wdata = 32'h1234;
        cyc();
        chk("t2 data first", m_addr, 32'h8000_0004); chk("t2 load wdata", m_wdata, 0);
        cyc();
        chk("t2 d_ack_n", d_ack_n, 0); chk("t2 d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t2 i_ack_n held", i_ack_n, 1);
        d_req = 0;
        cyc();
        chk("t2 idle gap", m_req, 0);
        cyc();
        chk("t2 fetch next", m_addr, 32'h20); chk("t2 fetch req", m_req, 1);
        cyc();
        chk("t2 i_ack_n", i_ack_n, 0);
        i_req = 0;
        cyc();

        // Starvation guard
        i_addr = 32'h100; d_addr = 32'h200; d_write = 0; i_req = 1; d_req = 1;
        glog.delete();
        for (int c = 0; c < 33; c++) begin
            cyc();
            if (m_req && mbusy == 1) glog.push_back((m_addr == 32'h200) ? 8'h44 : 8'h49);
            d_req = d_ack_n;
            i_req = i_ack_n;
        end
        i_req = 0; d_req = 0;
        repeat (4) cyc();
        exp_order = "DDDDIDDDDI";
        chk("t3 grants seen", (glog.size() >= 10), 1);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            chk($sformatf("t3 grant %0d", k), glog[k], exp_order[k]);

        // Store byte
        mdata = 32'h55; d_req = 1; d_write = 1; d_size = 2'b10;
        d_addr = 32'hF000_0000; d_wdata = 32'h41;
        cyc();
        chk("t4 m_write", m_write, 1); chk("t4 m_size", m_size, 2'b10);
        chk("t4 m_wdata", m_wdata, 32'h41); chk("t4 m_addr", m_addr, 32'hF000_0000);
        cyc();
        chk("t4 d_ack_n", d_ack_n, 0);
        d_req = 0; d_write = 0;
        cyc();
        chk("t4 single pulse", d_ack_n, 1);

        // Timeout abort, then ack on the last allowed cycle
        for (int t = 0; t < 2; t++) begin
            mode = (t == 0) ? 2 : 3; ack_at = TMO; mdata = 32'h77;
            d_req = 1; d_write = 0; d_size = 2'b00; d_addr = 32'h40;
            nb = 0; seen = 0;
            for (int k = 0; k < 400 && !seen; k++) begin
                cyc();
                if (m_req) nb++;
                if (!d_ack_n) begin
                    seen = 1;
                    chk($sformatf("t5.%0d err", t), err, (t == 0));
                    chk($sformatf("t5.%0d d_rdata", t), d_rdata, (t == 0) ? 32'h0 : 32'h77);
                    d_req = 0;
                end
            end
            chk($sformatf("t5.%0d ack seen", t), seen, 1);
            chk($sformatf("t5.%0d busy cycles", t), nb, TMO);
            cyc();
            chk($sformatf("t5.%0d err clear", t), err, 0);
            chk($sformatf("t5.%0d idle", t), m_req, 0);
        end

        // Asynchronous reset in the middle of an access
        mode = 2; i_req = 1; i_addr = 32'h50;
        cyc(); cyc();
        chk("t6 busy before rst", m_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6 m_req", m_req, 0); chk("t6 i_ack_n", i_ack_n, 1);
        chk("t6 d_ack_n", d_ack_n, 1); chk("t6 err", err, 0);
        cyc(); i_req = 0; cyc();
        rst = 1'b0;
        mode = 1; mdata = 32'h99; i_req = 1; i_addr = 32'h30;
        cyc();
        chk("t6 regrant", m_req, 1); chk("t6 regrant addr", m_addr, 32'h30);
        cyc();
        chk("t6 i_ack_n", i_ack_n, 0); chk("t6 i_rdata", i_rdata, 32'h99);
        i_req = 0;
        cyc();

        // Randomized traffic
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (!e_iack) i_req = 0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
            else if (i_req && $urandom_range(0, 19) == 0) i_req = 0;
            if (!e_dack) d_req = 0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_write = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
                d_addr = $urandom; d_wdata = $urandom;
            end else if (d_req && $urandom_range(0, 19) == 0) d_req = 0;
            if ($urandom_range(0, 9) == 0) begin i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; end
        end
        i_req = 0; d_req = 0;
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
